stm32_audio_ingress: RTL and testbench
======================================

// Module: stm32_audio_ingress
// PURPOSE
//  Upstream feeder for the DE1 codec Audio_Controller. Takes STM32 parallel samples (audio_in + async audio_wr strobe).
//  Synchronises the strobe, buffers samples in a FIFO, pre-fills, then streams to the controller on audio_out_allowed.
//  Returns flow control (audio_ready) to the STM32. Mono in; same sample driven on left and right.
// PARAMETERS
//  DATA_WIDTH   16  sample width, two's complement
//  FIFO_DEPTH   64  entries, power of 2, >= 8
//  SYNC_STAGES  2   flops on each async input (audio_wr, audio_enable), >= 2
//  READY_MARGIN 4   audio_ready drops when level >= FIFO_DEPTH-READY_MARGIN
// PORTS
//  CLOCK_50                 in   1              system clock, 50 MHz
//  reset                    in   1              synchronous, active-high
//  audio_in                 in   DATA_WIDTH     STM32 sample bus, async, quasi-static around strobe
//  audio_wr                 in   1              STM32 write strobe, async, sample taken on rising edge
//  audio_enable             in   1              STM32 enable, async, level
//  audio_ready              out  1              to STM32: space available and enabled
//  audio_out_allowed        in   1              from Audio_Controller: may accept a sample this cycle
//  write_audio_out          out  1              to Audio_Controller: 1-cycle write strobe per sample
//  left_channel_audio_out   out  DATA_WIDTH     sample to controller
//  right_channel_audio_out  out  DATA_WIDTH     identical to left
//  fifo_level               out  $clog2(FIFO_DEPTH)+1  current occupancy
//  overflow_sticky          out  1              sample dropped while full; cleared by reset or disable
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; state S_DISABLED; sync flops 0.
//  Sync: wr_s/en_s = SYNC_STAGES-flop copies. Push event = wr_s & ~wr_s_d (one per STM32 strobe).
//  Capture: audio_in sampled in the push-event cycle. STM32 contract: data valid >= 1 clk before wr rise,
//   held >= SYNC_STAGES+2 clks after.
//  Push: accepted if !full, or full with a pop in the same cycle. Otherwise dropped; overflow_sticky <= 1.
//  Simultaneous push+pop: level unchanged. Pointers wrap modulo FIFO_DEPTH. Level width is log2+1.
//  FIFO is show-ahead: head word visible combinationally. Pop = write_audio_out.
//  FSM (audio_ingress_pkg::state_t):
//   S_DISABLED: FIFO flushed, pushes ignored, overflow_sticky cleared. en_s=1 -> S_FILL.
//   S_FILL: pushes only, no writes. level >= FIFO_DEPTH/2 -> S_STREAM.
//   S_STREAM: write_audio_out = audio_out_allowed & !empty (same cycle, one sample/cycle max).
//    Outputs carry the head word while writing, and hold their last value otherwise.
//    allowed & empty = underrun -> S_FILL next cycle.
//   Any state, en_s=0 -> S_DISABLED. Same cycle: write_audio_out forced 0; flush occurs on entry.
//  audio_ready = en_s & (state != S_DISABLED) & (level < FIFO_DEPTH-READY_MARGIN). Registered, 1-cycle lag.
//  Latency: strobe rise -> fifo_level increment = SYNC_STAGES+1 clks.
//  Reset mid-stream: abandons FIFO contents, returns to reset values next edge.
// CONFIGURATION
//  Macro AUDIO_INGRESS_STATS_EN.
//  Defined: adds ports underrun_count out 16 and drop_count out 16, both saturating.
//   Incremented per underrun event / per dropped push. Cleared by reset only.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  audio_ingress_pkg: state_t enum {S_DISABLED,S_FILL,S_STREAM}; AUDIO_DATA_WIDTH=16; default FIFO_DEPTH.
//  Sub-module sample_fifo: sync show-ahead FIFO.
//   Interface: push, pop, wdata, rdata, full, empty, level, flush.
//  Top: synchronisers, edge detect, FSM, ready logic, optional stats.
// TESTING
//  1. Enable, 32 strobes of 0x0001..0x0020, allowed=1 -> no write until level hits 32.
//     Then 0x0001..0x0020 written in order, L==R.
//  2. allowed=0, 70 strobes -> level 64; audio_ready 0 at level 60; 6 drops.
//     overflow_sticky=1; drop_count=6 if STATS_EN.
//  3. Stream, then STM32 stops -> FIFO drains; allowed with empty -> write_audio_out 0, state S_FILL.
//     underrun_count=1 if STATS_EN; outputs hold last sample.
//  4. Full FIFO, push and pop in same cycle -> level stays 64, no overflow.
//  5. Drop audio_enable mid-stream -> write_audio_out 0 within SYNC_STAGES clks; level 0 next cycle.
//     audio_ready 0; overflow_sticky cleared.
//  6. Assert reset mid-stream with level 40 -> all outputs 0, level 0 after one edge; re-enable refills from empty.

Source files
------------

// File: rtl/audio_ingress_pkg.sv
// Shared types and defaults for the STM32 audio ingress block.
package audio_ingress_pkg;

  localparam int AUDIO_DATA_WIDTH = 16;
  localparam int AUDIO_FIFO_DEPTH = 64;

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_FILL     = 2'd1,
    S_STREAM   = 2'd2
  } state_t;

  // Saturating increment for the 16-bit statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO: the head word is visible on rdata_o without a pop.
module sample_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DW-1:0]            wdata_i,
  output logic [DW-1:0]            rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/stm32_audio_ingress.sv
// STM32 parallel-sample ingress feeding the DE1 Audio_Controller.
// Optional statistics counters are built when AUDIO_INGRESS_STATS_EN is defined.
module stm32_audio_ingress
  import audio_ingress_pkg::*;
#(
  parameter int DATA_WIDTH   = AUDIO_DATA_WIDTH,
  parameter int FIFO_DEPTH   = AUDIO_FIFO_DEPTH,
  parameter int SYNC_STAGES  = 2,
  parameter int READY_MARGIN = 4
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         audio_in,
  input  logic                          audio_wr,
  input  logic                          audio_enable,
  output logic                          audio_ready,
  input  logic                          audio_out_allowed,
  output logic                          write_audio_out,
  output logic [DATA_WIDTH-1:0]         left_channel_audio_out,
  output logic [DATA_WIDTH-1:0]         right_channel_audio_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow_sticky,
`ifdef AUDIO_INGRESS_STATS_EN
  output logic [15:0]                   underrun_count,
  output logic [15:0]                   drop_count,
`endif
  output state_t                        fsm_state
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] READY_LIMIT = LW'(FIFO_DEPTH - READY_MARGIN);
  localparam logic [LW-1:0] HALF_LEVEL  = LW'(FIFO_DEPTH / 2);

  logic [SYNC_STAGES-1:0] wr_sync_q;
  logic [SYNC_STAGES-1:0] en_sync_q;
  logic                   wr_s_prev_q;
  logic                   wr_s;
  logic                   en_s;

  state_t                 state_q;
  logic                   ready_q;
  logic                   ovf_q;
  logic [DATA_WIDTH-1:0]  last_q;

  logic                   active;
  logic                   push_evt;
  logic                   push_try;
  logic                   push_ok;
  logic                   drop;
  logic                   write;
  logic                   underrun;

  logic [DATA_WIDTH-1:0]  rdata;
  logic                   full;
  logic                   empty;
  logic [LW-1:0]          level;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_sync_q   <= '0;
      en_sync_q   <= '0;
      wr_s_prev_q <= 1'b0;
    end else begin
      wr_sync_q   <= {wr_sync_q[SYNC_STAGES-2:0], audio_wr};
      en_sync_q   <= {en_sync_q[SYNC_STAGES-2:0], audio_enable};
      wr_s_prev_q <= wr_s;
    end
  end

  assign wr_s     = wr_sync_q[SYNC_STAGES-1];
  assign en_s     = en_sync_q[SYNC_STAGES-1];
  assign push_evt = wr_s & ~wr_s_prev_q;

  // Outside S_DISABLED with the enable high the FIFO is live; otherwise it is held flushed.
  assign active   = en_s & (state_q != S_DISABLED);
  assign push_try = push_evt & active;
  assign write    = (state_q == S_STREAM) & en_s & audio_out_allowed & ~empty;
  assign underrun = (state_q == S_STREAM) & en_s & audio_out_allowed & empty;
  assign push_ok  = push_try & (~full | write);
  assign drop     = push_try & ~push_ok;

  sample_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .flush_i (~active),
    .push_i  (push_ok),
    .pop_i   (write),
    .wdata_i (audio_in),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_DISABLED;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      ready_q <= active & (level < READY_LIMIT);
      if (write) last_q <= rdata;
      if (!active)   ovf_q <= 1'b0;
      else if (drop) ovf_q <= 1'b1;
      if (!en_s) begin
        state_q <= S_DISABLED;
      end else begin
        case (state_q)
          S_DISABLED: state_q <= S_FILL;
          S_FILL:     if (level >= HALF_LEVEL) state_q <= S_STREAM;
          S_STREAM:   if (underrun) state_q <= S_FILL;
          default:    state_q <= S_DISABLED;
        endcase
      end
    end
  end

  // The controller sees the head word during a write and the last written sample otherwise.
  assign write_audio_out         = write;
  assign left_channel_audio_out  = write ? rdata : last_q;
  assign right_channel_audio_out = write ? rdata : last_q;
  assign audio_ready             = ready_q;
  assign fifo_level              = level;
  assign overflow_sticky         = ovf_q;
  assign fsm_state               = state_q;

`ifdef AUDIO_INGRESS_STATS_EN
  logic [15:0] underrun_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      underrun_cnt_q <= '0;
      drop_cnt_q     <= '0;
    end else begin
      if (underrun) underrun_cnt_q <= sat_inc16(underrun_cnt_q);
      if (drop)     drop_cnt_q     <= sat_inc16(drop_cnt_q);
    end
  end

  assign underrun_count = underrun_cnt_q;
  assign drop_count     = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stm32_audio_ingress.sv
// Bench for stm32_audio_ingress: queue-based reference model, per-cycle compare, directed and random phases.
module tb_stm32_audio_ingress;
  import audio_ingress_pkg::*;

  localparam int DW     = 16;
  localparam int DEPTH  = 64;
  localparam int SYNC   = 2;
  localparam int MARGIN = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] audio_in = '0;
  logic          audio_wr = 1'b0;
  logic          audio_enable = 1'b0;
  logic          audio_out_allowed = 1'b0;
  logic          audio_ready;
  logic          write_audio_out;
  logic [DW-1:0] left_out;
  logic [DW-1:0] right_out;
  logic [6:0]    fifo_level;
  logic          overflow_sticky;
  state_t        fsm_state;
`ifdef AUDIO_INGRESS_STATS_EN
  logic [15:0]   underrun_count;
  logic [15:0]   drop_count;
`endif

  always #5 clk = ~clk;

  stm32_audio_ingress #(
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH),
    .SYNC_STAGES  (SYNC),
    .READY_MARGIN (MARGIN)
  ) dut (
    .CLOCK_50                (clk),
    .reset                   (reset),
    .audio_in                (audio_in),
    .audio_wr                (audio_wr),
    .audio_enable            (audio_enable),
    .audio_ready             (audio_ready),
    .audio_out_allowed       (audio_out_allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_out),
    .right_channel_audio_out (right_out),
    .fifo_level              (fifo_level),
    .overflow_sticky         (overflow_sticky),
`ifdef AUDIO_INGRESS_STATS_EN
    .underrun_count          (underrun_count),
    .drop_count              (drop_count),
`endif
    .fsm_state               (fsm_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errs   = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  state_t        m_st = S_DISABLED;
  bit            m_ovf, m_ready, m_valid;
  logic [DW-1:0] m_last = '0;
  int            m_ucnt, m_dcnt, m_lvl;
  bit            m_wr_h [0:SYNC];
  bit            m_en_h [0:SYNC];

  bit            p_rst, p_allowed, p_wr, p_en, p_en_s, p_push, p_active, p_write;
  logic [DW-1:0] p_din, p_left;

  int pin_req = 0;
  int pin_seq = 0;
  int pin_done = 0;

  // Compare process: derive expected outputs from the model, check every cycle, serve literal pins.
  always @(negedge clk) begin
    p_rst     = reset;
    p_allowed = audio_out_allowed;
    p_wr      = audio_wr;
    p_en      = audio_enable;
    p_din     = audio_in;
    p_en_s    = m_en_h[SYNC-1];
    p_active  = p_en_s && (m_st != S_DISABLED);
    p_push    = m_wr_h[SYNC-1] && !m_wr_h[SYNC] && p_active;
    p_write   = (m_st == S_STREAM) && p_en_s && p_allowed && (exp_q.size() > 0);
    p_left    = p_write ? exp_q[0] : m_last;
    if (m_valid) begin
      chk("level", fifo_level, exp_q.size());
      chk("write", write_audio_out, p_write);
      chk("left", left_out, p_left);
      chk("right", right_out, p_left);
      chk("ready", audio_ready, m_ready);
      chk("overflow", overflow_sticky, m_ovf);
      chk("state", fsm_state, m_st);
`ifdef AUDIO_INGRESS_STATS_EN
      chk("underrun_count", underrun_count, m_ucnt);
      chk("drop_count", drop_count, m_dcnt);
`endif
      if (write_audio_out === 1'b1) got_q.push_back(left_out);
    end
    if (pin_seq != pin_done) begin
      case (pin_req)
        1: begin
          chk("rst_level", fifo_level, 0);
          chk("rst_write", write_audio_out, 0);
          chk("rst_ready", audio_ready, 0);
          chk("rst_ovf", overflow_sticky, 0);
          chk("rst_left", left_out, 0);
          chk("rst_state", fsm_state, S_DISABLED);
          got_q.delete();
        end
        2: begin
          chk("t1_count", got_q.size(), 32);
          for (int i = 0; i < 32 && i < got_q.size(); i++) chk("t1_order", got_q[i], i + 1);
`ifdef AUDIO_INGRESS_STATS_EN
          chk("t1_underrun", underrun_count, 1);
`endif
          got_q.delete();
        end
        3: begin
          chk("t2_level", fifo_level, 64);
          chk("t2_ovf", overflow_sticky, 1);
          chk("t2_ready", audio_ready, 0);
`ifdef AUDIO_INGRESS_STATS_EN
          chk("t2_drops", drop_count, 6);
`endif
        end
        4: begin
          chk("t5_level", fifo_level, 0);
          chk("t5_ready", audio_ready, 0);
          chk("t5_ovf", overflow_sticky, 0);
          chk("t5_write", write_audio_out, 0);
          chk("t5_state", fsm_state, S_DISABLED);
        end
        5: begin
          chk("t4_full_level", fifo_level, 64);
          chk("t4_full_ovf", overflow_sticky, 0);
        end
        6: begin
          chk("t4_pp_level", fifo_level, 64);
          chk("t4_pp_ovf", overflow_sticky, 0);
`ifdef AUDIO_INGRESS_STATS_EN
          chk("t4_pp_drops", drop_count, 6);
`endif
        end
        7: begin
          chk("t3_level", fifo_level, 0);
          chk("t3_write", write_audio_out, 0);
          chk("t3_state", fsm_state, S_FILL);
          chk("t3_left_hold", left_out, 16'hBEEF);
          chk("t3_right_hold", right_out, 16'hBEEF);
`ifdef AUDIO_INGRESS_STATS_EN
          chk("t3_underrun", underrun_count, 2);
`endif
        end
        8: chk("t6_level40", fifo_level, 40);
        9: begin
          chk("t6_rst_level", fifo_level, 0);
          chk("t6_rst_write", write_audio_out, 0);
          chk("t6_rst_ready", audio_ready, 0);
          chk("t6_rst_ovf", overflow_sticky, 0);
          chk("t6_rst_left", left_out, 0);
          chk("t6_rst_state", fsm_state, S_DISABLED);
        end
        10: chk("t6_refill", fifo_level, 3);
        default: chk("pin_id", pin_req, 0);
      endcase
      pin_done = pin_seq;
    end
  end

  // Model update at the clock edge from the values captured half a cycle earlier.
  always @(posedge clk) begin
    if (p_rst) begin
      m_valid = 1'b1;
      m_st    = S_DISABLED;
      exp_q.delete();
      m_ovf   = 1'b0;
      m_ready = 1'b0;
      m_last  = '0;
      m_ucnt  = 0;
      m_dcnt  = 0;
      for (int k = 0; k <= SYNC; k++) begin
        m_wr_h[k] = 1'b0;
        m_en_h[k] = 1'b0;
      end
    end else if (m_valid) begin
      m_lvl   = exp_q.size();
      m_ready = p_active && (m_lvl < DEPTH - MARGIN);
      if (!p_active) begin
        exp_q.delete();
        m_ovf = 1'b0;
      end else begin
        if (p_write) begin
          m_last = exp_q[0];
          void'(exp_q.pop_front());
        end
        if (p_push) begin
          if (m_lvl < DEPTH || p_write) exp_q.push_back(p_din);
          else begin
            m_ovf = 1'b1;
            if (m_dcnt < 65535) m_dcnt++;
          end
        end
      end
      if (!p_en_s) m_st = S_DISABLED;
      else if (m_st == S_DISABLED) m_st = S_FILL;
      else if (m_st == S_FILL && m_lvl >= DEPTH / 2) m_st = S_STREAM;
      else if (m_st == S_STREAM && p_allowed && m_lvl == 0) begin
        m_st = S_FILL;
        if (m_ucnt < 65535) m_ucnt++;
      end
      for (int k = SYNC; k > 0; k--) begin
        m_wr_h[k] = m_wr_h[k-1];
        m_en_h[k] = m_en_h[k-1];
      end
      m_wr_h[0] = p_wr;
      m_en_h[0] = p_en;
    end
  end

  // ---------------- driver tasks ----------------
  bit rand_allowed = 1'b0;
  int allowed_pct  = 50;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_allowed) audio_out_allowed = ($urandom_range(0, 99) < allowed_pct);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pin(input int id);
    pin_req = id;
    pin_seq++;
    tick();
  endtask

  // One STM32 write: data set a cycle before the rise and held well past the capture point.
  task automatic strobe(input logic [DW-1:0] d, input bit pop_on_push, input int low_ticks);
    audio_in = d;
    tick();
    audio_wr = 1'b1;
    for (int i = 0; i < SYNC + 2; i++) begin
      tick();
      if (pop_on_push && i == SYNC - 1) audio_out_allowed = 1'b1;
      else if (pop_on_push && i == SYNC) audio_out_allowed = 1'b0;
    end
    audio_wr = 1'b0;
    ticks(low_ticks);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ticks(3);
    pin(1);
    reset = 1'b0;

    audio_enable = 1'b1;
    ticks(4);
    audio_out_allowed = 1'b1;
    for (int i = 1; i <= 32; i++) strobe(DW'(i), 1'b0, 2);
    ticks(45);
    pin(2);

    audio_out_allowed = 1'b0;
    for (int i = 0; i < 70; i++) strobe(DW'(16'h0200 + i), 1'b0, 2);
    ticks(3);
    pin(3);

    audio_enable = 1'b0;
    ticks(5);
    pin(4);
    audio_enable = 1'b1;
    ticks(4);

    for (int i = 0; i < 64; i++) strobe(DW'(16'h0100 + i), 1'b0, 2);
    ticks(2);
    pin(5);
    strobe(16'hBEEF, 1'b1, 2);
    ticks(2);
    pin(6);

    audio_out_allowed = 1'b1;
    ticks(70);
    pin(7);

    audio_out_allowed = 1'b0;
    for (int i = 0; i < 40; i++) strobe(DW'(16'h0300 + i), 1'b0, 2);
    ticks(2);
    pin(8);
    reset = 1'b1;
    tick();
    pin(9);
    reset = 1'b0;
    ticks(5);
    for (int i = 0; i < 3; i++) strobe(DW'(16'h0400 + i), 1'b0, 2);
    ticks(2);
    pin(10);

    rand_allowed = 1'b1;
    for (int ph = 0; ph < 3; ph++) begin
      allowed_pct = (ph == 0) ? 8 : (ph == 1) ? 50 : 90;
      for (int n = 0; n < 60; n++) begin
        strobe(DW'($urandom_range(0, 16'hFFFF)), 1'b0, $urandom_range(1, 3));
        if ($urandom_range(0, 24) == 0) begin
          audio_enable = 1'b0;
          ticks($urandom_range(1, 8));
          audio_enable = 1'b1;
        end
        if ($urandom_range(0, 59) == 0) begin
          reset = 1'b1;
          tick();
          reset = 1'b0;
        end
      end
    end
    rand_allowed = 1'b0;
    ticks(4);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
